// File: rtl/if_fetch_stage.sv
// IF stage: drives imem with the current pc, tracks the 1-cycle read, skids data across stalls, squashes on flush.
// Optional FETCH_MISALIGN_CHECK_EN: flags pc_out[1:0]!=0 and substitutes a NOP for the instruction.
module if_fetch_stage #(
  parameter int unsigned XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] pc_4_in,
  input  logic            stall,
  input  logic            mmm_stall,
  input  logic            flush,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instr_out,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_4_out,
  output logic            valid_out,
  output logic            misaligned_out
);

  localparam int unsigned ILEN = 32;

  logic            hold;
  logic [XLEN-1:0] req_pc;
  logic [XLEN-1:0] req_pc4;
  logic            req_valid;
  logic [ILEN-1:0] skid_instr;
  logic [XLEN-1:0] skid_pc;
  logic [XLEN-1:0] skid_pc4;
  logic            skid_valid;

  logic [ILEN-1:0] ld_instr;
  logic [XLEN-1:0] ld_pc;
  logic [XLEN-1:0] ld_pc4;
  logic            ld_valid;

  assign hold      = stall | mmm_stall;
  assign imem_addr = pc_in;

  // Request tracking: remembers which pc the memory is currently answering for.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      req_valid <= 1'b0;
    end else if (!hold) begin
      req_pc    <= pc_in;
      req_pc4   <= pc_4_in;
      req_valid <= 1'b1;
    end
  end

  // Skid: the memory does not hold its data, so catch it on the first stalled cycle only.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      skid_valid <= 1'b0;
    end else if (hold) begin
      if (req_valid && !skid_valid) begin
        skid_instr <= imem_rdata;
        skid_pc    <= req_pc;
        skid_pc4   <= req_pc4;
        skid_valid <= 1'b1;
      end
    end else begin
      skid_valid <= 1'b0;
    end
  end

  // Source selection for the IF/ID register: skid first, then the live memory return.
  always_comb begin
    ld_instr = imem_rdata;
    ld_pc    = req_pc;
    ld_pc4   = req_pc4;
    ld_valid = req_valid;
    if (skid_valid) begin
      ld_instr = skid_instr;
      ld_pc    = skid_pc;
      ld_pc4   = skid_pc4;
      ld_valid = 1'b1;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  logic ld_mis;

  assign ld_mis = (ld_pc[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out      <= 1'b0;
      instr_out      <= NOP_INSTR;
      pc_out         <= '0;
      pc_4_out       <= '0;
      misaligned_out <= 1'b0;
    end else if (flush) begin
      valid_out      <= 1'b0;
      instr_out      <= NOP_INSTR;
      misaligned_out <= 1'b0;
    end else if (!hold) begin
      if (ld_valid) begin
        valid_out      <= 1'b1;
        instr_out      <= ld_mis ? NOP_INSTR : ld_instr;
        pc_out         <= ld_pc;
        pc_4_out       <= ld_pc4;
        misaligned_out <= ld_mis;
      end else begin
        valid_out      <= 1'b0;
        instr_out      <= NOP_INSTR;
        misaligned_out <= 1'b0;
      end
    end
  end
`else
  assign misaligned_out = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out <= 1'b0;
      instr_out <= NOP_INSTR;
      pc_out    <= '0;
      pc_4_out  <= '0;
    end else if (flush) begin
      valid_out <= 1'b0;
      instr_out <= NOP_INSTR;
    end else if (!hold) begin
      if (ld_valid) begin
        valid_out <= 1'b1;
        instr_out <= ld_instr;
        pc_out    <= ld_pc;
        pc_4_out  <= ld_pc4;
      end else begin
        valid_out <= 1'b0;
        instr_out <= NOP_INSTR;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: directed pc streams with stalls, flushes and resets.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in;
  logic [31:0] pc_4_in;
  logic        stall;
  logic        mmm_stall;
  logic        flush;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [31:0] pc_4_out;
  logic        valid_out;
  logic        misaligned_out;
  logic        garbage;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        mis;
  } exp_t;

  exp_t q[$];

  if_fetch_stage #(.XLEN(32), .NOP_INSTR(32'h0000_0013)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .pc_4_in(pc_4_in),
    .stall(stall), .mmm_stall(mmm_stall), .flush(flush),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instr_out(instr_out), .pc_out(pc_out), .pc_4_out(pc_4_out),
    .valid_out(valid_out), .misaligned_out(misaligned_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0004: return 32'h0010_8113;
      32'h0000_0008: return 32'h0020_81B3;
      32'h0000_0040: return 32'h0000_0463;
      default:       return 32'hA000_0000 ^ a;
    endcase
  endfunction

  // Synchronous instruction memory; returns junk while garbage is set.
  always @(posedge clk) imem_rdata <= garbage ? 32'hDEAD_BEEF : mem_f(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.pc4   = pc + 32'd4;
    e.mis   = 1'b0;
    e.instr = mem_f(pc);
`ifdef FETCH_MISALIGN_CHECK_EN
    if (pc[1:0] != 2'b00) begin
      e.mis   = 1'b1;
      e.instr = NOP;
    end
`endif
    q.push_back(e);
  endtask

  // Drive one cycle of inputs; ex marks a pc whose instruction must eventually emerge.
  task automatic cyc(input logic [31:0] pc, input logic st, input logic mst, input logic fl,
                     input logic rs, input logic gb, input logic ex);
    pc_in     = pc;
    pc_4_in   = pc + 32'd4;
    stall     = st;
    mmm_stall = mst;
    flush     = fl;
    reset     = rs;
    garbage   = gb;
    if (ex) push_exp(pc);
    @(posedge clk);
    #1;
  endtask

  // Monitor: classify each edge by the controls it saw, then check the outputs it produced.
  logic        ev_rst  = 1'b1;
  logic        ev_fl   = 1'b0;
  logic        ev_hold = 1'b0;
  logic [31:0] l_instr, l_pc, l_pc4;
  logic        l_valid, l_mis;

  always @(posedge clk) begin
    ev_rst  <= reset;
    ev_fl   <= flush;
    ev_hold <= stall | mmm_stall;
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (ev_rst) begin
      chk("rst_valid", 32'(valid_out), 32'd0);
      chk("rst_instr", instr_out, NOP);
      chk("rst_pc", pc_out, 32'd0);
      chk("rst_pc4", pc_4_out, 32'd0);
      chk("rst_mis", 32'(misaligned_out), 32'd0);
    end else if (ev_fl) begin
      chk("flush_valid", 32'(valid_out), 32'd0);
      chk("flush_instr", instr_out, NOP);
      chk("flush_pc_kept", pc_out, l_pc);
      chk("flush_mis", 32'(misaligned_out), 32'd0);
    end else if (ev_hold) begin
      chk("hold_valid", 32'(valid_out), 32'(l_valid));
      chk("hold_instr", instr_out, l_instr);
      chk("hold_pc", pc_out, l_pc);
      chk("hold_pc4", pc_4_out, l_pc4);
      chk("hold_mis", 32'(misaligned_out), 32'(l_mis));
    end else if (valid_out) begin
      if (q.size() == 0) begin
        chk("unexpected_valid", 32'(valid_out), 32'd0);
      end else begin
        e = q.pop_front();
        chk("instr", instr_out, e.instr);
        chk("pc", pc_out, e.pc);
        chk("pc4", pc_4_out, e.pc4);
        chk("mis", 32'(misaligned_out), 32'(e.mis));
      end
    end else begin
      chk("idle_instr", instr_out, NOP);
    end
    l_instr = instr_out;
    l_pc    = pc_out;
    l_pc4   = pc_4_out;
    l_valid = valid_out;
    l_mis   = misaligned_out;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; stall = 1'b0; mmm_stall = 1'b0; flush = 1'b0; garbage = 1'b0;
    pc_in = '0; pc_4_in = 32'd4;
    cyc(32'h0, 0, 0, 0, 1, 0, 0);
    cyc(32'h0, 0, 0, 0, 1, 0, 0);

    // Straight-line fetch of three instructions, then reset
    cyc(32'h0, 0, 0, 0, 0, 0, 1);
    cyc(32'h4, 0, 0, 0, 0, 0, 1);
    cyc(32'h8, 0, 0, 0, 0, 0, 1);
    cyc(32'hC, 0, 0, 0, 0, 0, 0);
    cyc(32'hC, 0, 0, 0, 1, 0, 0);

    // Stall 3 cycles with pc=4 in flight and junk on the memory bus
    cyc(32'h0, 0, 0, 0, 0, 0, 1);
    cyc(32'h4, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(32'h8, 1, 0, 0, 0, 1, 0);
    cyc(32'h8, 0, 0, 0, 0, 0, 1);

    // Both stall sources for 5 cycles
    cyc(32'hC, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(32'h10, 1, 1, 0, 0, 1, 0);
    cyc(32'h10, 0, 0, 0, 0, 0, 1);
    cyc(32'h14, 0, 0, 0, 0, 0, 0);

    // Flush with redirect to 0x40
    cyc(32'h18, 0, 0, 1, 0, 0, 0);
    cyc(32'h40, 0, 0, 0, 0, 0, 1);
    cyc(32'h44, 0, 0, 0, 0, 0, 0);

    // Flush and stall together, then reset mid-stall
    cyc(32'h48, 1, 0, 1, 0, 0, 0);
    cyc(32'h48, 1, 0, 0, 0, 0, 0);
    cyc(32'h48, 1, 0, 0, 1, 0, 0);
    cyc(32'h48, 0, 0, 0, 0, 0, 1);
    cyc(32'h4C, 0, 0, 0, 0, 0, 1);

    // Redirect on the cycle a stall releases with a full skid
    cyc(32'h80, 0, 0, 0, 0, 0, 1);
    cyc(32'h84, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) cyc(32'h88, 1, 0, 0, 0, 1, 0);
    cyc(32'h88, 0, 0, 1, 0, 0, 0);
    cyc(32'hC0, 0, 0, 0, 0, 0, 1);
    cyc(32'hC4, 0, 0, 0, 0, 0, 1);

    // Misaligned pc and address wrap
    cyc(32'h42, 0, 0, 0, 0, 0, 1);
    cyc(32'hFFFF_FFFC, 0, 0, 0, 0, 0, 1);
    cyc(32'h100, 0, 0, 0, 0, 0, 1);
    cyc(32'h104, 0, 0, 0, 0, 0, 0);
    cyc(32'h104, 0, 0, 0, 1, 0, 0);
    cyc(32'h0, 0, 0, 0, 1, 0, 0);

    @(negedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
